// File: rtl/address_unit_seq_pkg.sv
// rtl/address_unit_seq_pkg.sv - op encodings and FSM state codes for the address unit
package address_unit_seq_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_NEXT = 3'd0;
  localparam op_t OP_JREL = 3'd1;
  localparam op_t OP_JABS = 3'd2;
  localparam op_t OP_MEM  = 3'd3;
  localparam op_t OP_PUSH = 3'd4;
  localparam op_t OP_POP  = 3'd5;
  localparam op_t OP_CALL = 3'd6;
  localparam op_t OP_RET  = 3'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT1 = 2'd1;
  localparam logic [1:0] S_BEAT2 = 2'd2;

endpackage

// File: rtl/address_unit_seq_signext.sv
// rtl/address_unit_seq_signext.sv - generic two's-complement sign extender
module address_unit_seq_signext #(
  parameter int IW = 4,
  parameter int OW = 16
) (
  input  logic [IW-1:0] in_val,
  output logic [OW-1:0] out_val
);

  assign out_val = {{(OW-IW){in_val[IW-1]}}, in_val};

endmodule

// File: rtl/address_unit_seq.sv
// rtl/address_unit_seq.sv - sequential PC/SP address unit with load/store, push/pop and call/ret beats
module address_unit_seq
  import address_unit_seq_pkg::*;
#(
  parameter int              AW       = 16,
  parameter int              DW       = 8,
  parameter int              OFFS_W   = 4,
  parameter int              LOFFS_W  = 8,
  parameter logic [DW-1:0]   SP_PAGE  = 8'hFF,
  parameter logic [AW-1:0]   RESET_PC = 16'h0000,
  parameter logic [DW-1:0]   RESET_SP = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op,
  input  logic               st,
  input  logic [DW-1:0]      dx,
  input  logic [DW-1:0]      dy,
  input  logic [OFFS_W-1:0]  offs,
  input  logic [LOFFS_W-1:0] longoffs,
  input  logic [DW-1:0]      wdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic               mem_ack,
  input  logic [DW-1:0]      mem_rdata,
  output logic [DW-1:0]      ld_data,
  output logic               done,
  output logic [AW-1:0]      pc,
  output logic [DW-1:0]      sp
);

  localparam logic [AW-1:0] A_ONE = 1;
  localparam logic [DW-1:0] D_ONE = 1;
  localparam logic [DW-1:0] D_TWO = 2;

  logic [1:0]    state;
  op_t           op_q;
  logic [AW-1:0] target_q;
  logic [DW-1:0] lo_q;

  logic [AW-1:0] base, mofs, jofs, ret;
  logic [AW-1:0] b1_addr;
  logic          b1_we;
  logic [DW-1:0] b1_wdata;
  logic          beat_done;

  address_unit_seq_signext #(.IW(OFFS_W), .OW(AW)) u_mem_ofs (
    .in_val (offs),
    .out_val(mofs)
  );

  address_unit_seq_signext #(.IW(OFFS_W + LOFFS_W), .OW(AW)) u_jmp_ofs (
    .in_val ({offs, longoffs}),
    .out_val(jofs)
  );

  assign base      = {dy, dx};
  assign ret       = pc + A_ONE;
  assign op_ready  = (state == S_IDLE);
  assign beat_done = mem_req && mem_ack;

  // First-beat address/direction/data, selected from the op being accepted
  always_comb begin
    b1_addr  = {SP_PAGE, sp};
    b1_we    = 1'b1;
    b1_wdata = wdata;
    case (op)
      OP_MEM:  begin b1_addr = base + mofs; b1_we = st; end
      OP_POP,
      OP_RET:  begin b1_addr = {SP_PAGE, sp + D_ONE}; b1_we = 1'b0; end
      OP_CALL: b1_wdata = ret[AW-1:DW];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      sp        <= RESET_SP;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ld_data   <= '0;
      done      <= 1'b0;
      op_q      <= OP_NEXT;
      target_q  <= '0;
      lo_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (op_valid) begin
          op_q     <= op;
          target_q <= base;
          case (op)
            OP_NEXT: begin pc <= pc + A_ONE; done <= 1'b1; end
            OP_JREL: begin pc <= pc + jofs;  done <= 1'b1; end
            OP_JABS: begin pc <= base;       done <= 1'b1; end
            default: begin
              state     <= S_BEAT1;
              mem_req   <= 1'b1;
              mem_we    <= b1_we;
              mem_addr  <= b1_addr;
              mem_wdata <= b1_wdata;
              lo_q      <= ret[DW-1:0];
            end
          endcase
        end
        S_BEAT1: if (beat_done) begin
          if (op_q == OP_CALL || op_q == OP_RET) begin
            // Second byte follows immediately; sp itself only moves on the final ack
            state <= S_BEAT2;
            if (op_q == OP_CALL) begin
              mem_addr  <= {SP_PAGE, sp - D_ONE};
              mem_wdata <= lo_q;
            end else begin
              mem_addr <= {SP_PAGE, sp + D_TWO};
              lo_q     <= mem_rdata;
            end
          end else begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            pc      <= pc + A_ONE;
            done    <= 1'b1;
            if (!mem_we) ld_data <= mem_rdata;
            if (op_q == OP_PUSH) sp <= sp - D_ONE;
            if (op_q == OP_POP)  sp <= sp + D_ONE;
          end
        end
        S_BEAT2: if (beat_done) begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          done    <= 1'b1;
          if (op_q == OP_CALL) begin
            sp <= sp - D_TWO;
            pc <= target_q;
          end else begin
            sp <= sp + D_TWO;
            pc <= {mem_rdata, lo_q};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_address_unit_seq.sv
// tb/tb_address_unit_seq.sv - directed self-checking bench for address_unit_seq
module tb_address_unit_seq;
  import address_unit_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op = 3'd0;
  logic        st = 1'b0;
  logic [7:0]  dx = 8'h00, dy = 8'h00;
  logic [3:0]  offs = 4'h0;
  logic [7:0]  longoffs = 8'h00;
  logic [7:0]  wdata = 8'h00;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  ld_data;
  logic        done;
  logic [15:0] pc;
  logic [7:0]  sp;

  address_unit_seq dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op), .st(st),
    .dx(dx), .dy(dy), .offs(offs), .longoffs(longoffs), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ld_data(ld_data), .done(done),
    .pc(pc), .sp(sp)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int done_cnt = 0, req_cnt = 0;

  logic [7:0]  rdata_tbl [0:7];
  int          wait_tbl  [0:7];
  logic [15:0] log_addr  [0:7];
  logic        log_we    [0:7];
  logic [7:0]  log_wdata [0:7];
  int          log_held  [0:7];
  int          log_ack_cyc [0:7];
  bit          log_stable  [0:7];
  int          beat_n = 0;
  int          held = 0;
  bit          in_beat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_req) req_cnt++;
  end

  // Memory responder: records each beat, acks after wait_tbl[beat] idle cycles
  always @(negedge clk) begin
    if (mem_ack && in_beat) begin
      mem_ack = 1'b0;
      in_beat = 1'b0;
      beat_n++;
    end
    if (!mem_req) begin
      in_beat = 1'b0;
    end else if (beat_n < 8) begin
      if (!in_beat) begin
        in_beat = 1'b1;
        held = 0;
        log_addr[beat_n]   = mem_addr;
        log_we[beat_n]     = mem_we;
        log_wdata[beat_n]  = mem_wdata;
        log_stable[beat_n] = 1'b1;
      end else if (mem_addr !== log_addr[beat_n] || mem_we !== log_we[beat_n] ||
                   mem_wdata !== log_wdata[beat_n]) begin
        log_stable[beat_n] = 1'b0;
      end
      held++;
      log_held[beat_n] = held;
      if (held > wait_tbl[beat_n]) begin
        mem_ack = 1'b1;
        mem_rdata = rdata_tbl[beat_n];
        log_ack_cyc[beat_n] = cyc;
      end
    end
  end

  task automatic clear_log();
    beat_n = 0;
    done_cnt = 0;
    req_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      rdata_tbl[i] = 8'h00;
      wait_tbl[i] = 0;
      log_held[i] = 0;
      log_ack_cyc[i] = 0;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic s, input logic [7:0] y, input logic [7:0] x,
                        input logic [3:0] of, input logic [7:0] lo, input logic [7:0] wd,
                        output bit ok, output int done_at);
    int n;
    op = o; st = s; dy = y; dx = x; offs = of; longoffs = lo; wdata = wd;
    op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    ok = done;
    done_at = cyc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=0000", pc); end
    n_checks++; if (sp !== 8'hFF) begin n_fail++; $display("FAIL reset_sp got=%h exp=ff", sp); end
    n_checks++; if ({done, mem_we, mem_addr, mem_wdata, ld_data} !== 34'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", {done, mem_we, mem_addr, mem_wdata, ld_data}); end
    n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_op_ready got=%b exp=1", op_ready); end
    rst = 1'b0;
    #1;
    clear_log();
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    mem_ack = 1'b0;
    n_checks++; if ({done_cnt, req_cnt} !== 64'd0) begin n_fail++; $display("FAIL stray_ack_activity got=%0d/%0d exp=0/0", done_cnt, req_cnt); end
    n_checks++; if (pc !== 16'h0000 || sp !== 8'hFF) begin n_fail++; $display("FAIL stray_ack_regs got=%h/%h exp=0000/ff", pc, sp); end
  endtask

  task automatic test_next();
    bit ok; int t;
    clear_log();
    for (int i = 0; i < 3; i++) begin
      run_op(OP_NEXT, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, ok, t);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL next_done_timeout got=%b exp=1", ok); end
    end
    n_checks++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL next_pc got=%h exp=0003", pc); end
    n_checks++; if (done_cnt !== 3) begin n_fail++; $display("FAIL next_done_pulses got=%0d exp=3", done_cnt); end
    n_checks++; if (req_cnt !== 0) begin n_fail++; $display("FAIL next_mem_req got=%0d exp=0", req_cnt); end
  endtask

  task automatic test_jumps();
    bit ok; int t;
    clear_log();
    run_op(OP_JABS, 1'b0, 8'h01, 8'h00, 4'h0, 8'h00, 8'h00, ok, t);
    n_checks++; if (pc !== 16'h0100) begin n_fail++; $display("FAIL jabs_0100 got=%h exp=0100", pc); end
    run_op(OP_JREL, 1'b0, 8'h77, 8'h77, 4'hF, 8'hFE, 8'h00, ok, t);
    n_checks++; if (pc !== 16'h00FE) begin n_fail++; $display("FAIL jrel_neg got=%h exp=00fe", pc); end
    run_op(OP_JABS, 1'b0, 8'h12, 8'h34, 4'h0, 8'h00, 8'h00, ok, t);
    n_checks++; if (pc !== 16'h1234) begin n_fail++; $display("FAIL jabs_1234 got=%h exp=1234", pc); end
    n_checks++; if (req_cnt !== 0 || done_cnt !== 3) begin n_fail++; $display("FAIL jump_activity got=%0d/%0d exp=0/3", req_cnt, done_cnt); end
  endtask

  task automatic test_mem();
    bit ok; int t;
    clear_log();
    wait_tbl[0] = 3;
    rdata_tbl[0] = 8'h5C;
    run_op(OP_MEM, 1'b0, 8'h20, 8'h00, 4'hE, 8'h00, 8'h00, ok, t);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL load_done_timeout got=%b exp=1", ok); end
    n_checks++; if (log_addr[0] !== 16'h1FFE || log_we[0] !== 1'b0) begin n_fail++; $display("FAIL load_beat got=%h/%b exp=1ffe/0", log_addr[0], log_we[0]); end
    n_checks++; if (log_held[0] !== 4 || !log_stable[0]) begin n_fail++; $display("FAIL load_held got=%0d/%b exp=4/1", log_held[0], log_stable[0]); end
    n_checks++; if (ld_data !== 8'h5C) begin n_fail++; $display("FAIL load_data got=%h exp=5c", ld_data); end
    n_checks++; if (t !== log_ack_cyc[0] + 1) begin n_fail++; $display("FAIL load_done_latency got=%0d exp=%0d", t, log_ack_cyc[0] + 1); end
    n_checks++; if (pc !== 16'h1235 || done_cnt !== 1) begin n_fail++; $display("FAIL load_pc got=%h/%0d exp=1235/1", pc, done_cnt); end
    run_op(OP_MEM, 1'b1, 8'h00, 8'h10, 4'h7, 8'h00, 8'h99, ok, t);
    n_checks++; if (log_addr[1] !== 16'h0017 || log_we[1] !== 1'b1 || log_wdata[1] !== 8'h99) begin n_fail++; $display("FAIL store_beat got=%h/%b/%h exp=0017/1/99", log_addr[1], log_we[1], log_wdata[1]); end
    n_checks++; if (ld_data !== 8'h5C || pc !== 16'h1236) begin n_fail++; $display("FAIL store_side got=%h/%h exp=5c/1236", ld_data, pc); end
  endtask

  task automatic test_stack();
    bit ok; int t;
    clear_log();
    rdata_tbl[0] = 8'h77;
    rdata_tbl[2] = 8'hA5;
    run_op(OP_POP, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, ok, t);
    n_checks++; if (log_addr[0] !== 16'hFF00 || sp !== 8'h00 || ld_data !== 8'h77) begin n_fail++; $display("FAIL pop_wrap got=%h/%h/%h exp=ff00/00/77", log_addr[0], sp, ld_data); end
    run_op(OP_PUSH, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 8'hA5, ok, t);
    n_checks++; if (log_addr[1] !== 16'hFF00 || log_we[1] !== 1'b1 || log_wdata[1] !== 8'hA5) begin n_fail++; $display("FAIL push_beat got=%h/%b/%h exp=ff00/1/a5", log_addr[1], log_we[1], log_wdata[1]); end
    n_checks++; if (sp !== 8'hFF) begin n_fail++; $display("FAIL push_sp_wrap got=%h exp=ff", sp); end
    run_op(OP_POP, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, ok, t);
    n_checks++; if (log_addr[2] !== 16'hFF00 || log_we[2] !== 1'b0 || sp !== 8'h00 || ld_data !== 8'hA5) begin n_fail++; $display("FAIL pop_beat got=%h/%b/%h/%h exp=ff00/0/00/a5", log_addr[2], log_we[2], sp, ld_data); end
    run_op(OP_PUSH, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h3C, ok, t);
    n_checks++; if (sp !== 8'hFF || pc !== 16'h123A) begin n_fail++; $display("FAIL stack_end got=%h/%h exp=ff/123a", sp, pc); end
  endtask

  task automatic test_call_ret();
    bit ok; int t;
    run_op(OP_JABS, 1'b0, 8'h10, 8'hFF, 4'h0, 8'h00, 8'h00, ok, t);
    clear_log();
    wait_tbl[0] = 1;
    rdata_tbl[2] = 8'h00;
    rdata_tbl[3] = 8'h11;
    run_op(OP_CALL, 1'b0, 8'h40, 8'h00, 4'h0, 8'h00, 8'h00, ok, t);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL call_done_timeout got=%b exp=1", ok); end
    n_checks++; if (log_addr[0] !== 16'hFFFF || log_we[0] !== 1'b1 || log_wdata[0] !== 8'h11) begin n_fail++; $display("FAIL call_beat1 got=%h/%b/%h exp=ffff/1/11", log_addr[0], log_we[0], log_wdata[0]); end
    n_checks++; if (log_addr[1] !== 16'hFFFE || log_we[1] !== 1'b1 || log_wdata[1] !== 8'h00) begin n_fail++; $display("FAIL call_beat2 got=%h/%b/%h exp=fffe/1/00", log_addr[1], log_we[1], log_wdata[1]); end
    n_checks++; if (log_ack_cyc[1] !== log_ack_cyc[0] + 1 || t !== log_ack_cyc[1] + 1) begin n_fail++; $display("FAIL call_timing got=%0d/%0d exp=%0d/%0d", log_ack_cyc[1], t, log_ack_cyc[0] + 1, log_ack_cyc[1] + 1); end
    n_checks++; if (sp !== 8'hFD || pc !== 16'h4000) begin n_fail++; $display("FAIL call_regs got=%h/%h exp=fd/4000", sp, pc); end
    run_op(OP_RET, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, ok, t);
    n_checks++; if (log_addr[2] !== 16'hFFFE || log_addr[3] !== 16'hFFFF || log_we[2] !== 1'b0 || log_we[3] !== 1'b0) begin n_fail++; $display("FAIL ret_beats got=%h/%h exp=fffe/ffff", log_addr[2], log_addr[3]); end
    n_checks++; if (pc !== 16'h1100 || sp !== 8'hFF) begin n_fail++; $display("FAIL ret_regs got=%h/%h exp=1100/ff", pc, sp); end
  endtask

  task automatic test_reset_mid_call();
    int n;
    clear_log();
    wait_tbl[1] = 5;
    op = OP_CALL; dy = 8'h40; dx = 8'h00;
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    n = 0;
    while (!(beat_n == 1 && mem_req) && n < 20) begin @(negedge clk); #1; n++; end
    n_checks++; if (!(beat_n == 1 && mem_req)) begin n_fail++; $display("FAIL midcall_beat2_timeout got=%0d exp=1", beat_n); end
    rst = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midcall_req got=%b exp=0", mem_req); end
    n_checks++; if (pc !== 16'h0000 || sp !== 8'hFF || op_ready !== 1'b1) begin n_fail++; $display("FAIL midcall_regs got=%h/%h/%b exp=0000/ff/1", pc, sp, op_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    test_reset();
    test_next();
    test_jumps();
    test_mem();
    test_stack();
    test_call_ret();
    test_reset_mid_call();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
